mc_ctrl: RTL and testbench



---
 rtl/mc_pkg.sv | 42 ++++
 rtl/mc_ctrl_alu_dec.sv | 23 ++
 rtl/mc_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcode/funct
// constants, ALU operation codes and PC source selects.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;

    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct to ALU operation decoder; flags functs the datapath cannot execute.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       bad
);

    always_comb begin
        alu_op = ALU_ADD;
        bad    = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-ready stall.
// Optional macro MC_CTRL_PERF_EN adds cycle and retired-instruction counters.
//
// state  | meaning
// FETCH  | read instruction; on mem_ready load IR and PC+4
// DECODE | latch opcode/funct, trap unsupported encodings
// EXEC   | ALU op; beq/j resolve the PC and retire here
// MEM    | lw/sw access, held until mem_ready
// WB     | register file write, retire
// HALT   | illegal instruction seen; only reset leaves
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int ALU_W = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src,
    output logic [ALU_W-1:0] alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem2reg,
    output logic             retire,
    output logic             illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    if (ALU_W < 3 || CNT_W < 1) begin : g_param_check
        $error("mc_ctrl: ALU_W must be >= 3 and CNT_W >= 1");
    end

    state_t     state;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic       illegal_q;
    logic [5:0] fn_sel;
    logic [2:0] dec_op;
    logic       dec_bad;
    logic [2:0] alu_op3;

    // One decoder serves both the DECODE legality check (live funct) and EXEC (latched).
    assign fn_sel = (state == S_DECODE) ? funct : fn_q;

    mc_alu_dec u_alu_dec (
        .funct  (fn_sel),
        .alu_op (dec_op),
        .bad    (dec_bad)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            op_q      <= '0;
            fn_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    fn_q <= funct;
                    if (!opcode_legal(opcode) || (opcode == OP_RTYPE && dec_bad)) begin
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_LW, OP_SW:       state <= S_MEM;
                        OP_RTYPE, OP_ADDI:  state <= S_WB;
                        default:            state <= S_FETCH;
                    endcase
                end
                S_MEM: if (mem_ready) state <= (op_q == OP_LW) ? S_WB : S_FETCH;
                S_WB:     state <= S_FETCH;
                default:  state <= S_HALT;
            endcase
        end
    end

    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SEQ;
        reg_dst   = 1'b0;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        alu_op3   = ALU_ADD;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem2reg   = 1'b0;
        retire    = 1'b0;
        illegal   = illegal_q;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: alu_op3 = dec_op;
                    OP_ADDI, OP_LW, OP_SW: alu_src = 1'b1;
                    OP_BEQ: begin
                        alu_op3 = ALU_SUB;
                        retire  = 1'b1;
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_src   = PC_BR;
                        end
                    end
                    OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JMP;
                        retire   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                alu_src = 1'b1;
                if (op_q == OP_LW) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                    retire    = mem_ready;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                if (op_q == OP_RTYPE) reg_dst = 1'b1;
                if (op_q == OP_LW) begin
                    mem2reg = 1'b1;
                    alu_src = 1'b1;
                end
            end
            default: ;
        endcase
        if (!rst_n) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'd0;
            reg_dst   = 1'b0;
            reg_write = 1'b0;
            alu_src   = 1'b0;
            alu_op3   = 3'd0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem2reg   = 1'b0;
            retire    = 1'b0;
            illegal   = 1'b0;
        end
        alu_op = ALU_W'(alu_op3);
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != S_HALT) cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (retire)          ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle vector table plus stalled-memory
// and counter sequences.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       ir_write, pc_write, reg_dst, reg_write, alu_src;
    logic       mem_read, mem_write, mem2reg, retire, illegal;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.ALU_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read),
        .mem_write(mem_write), .mem2reg(mem2reg), .retire(retire),
        .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [14:0] exp;
        string       nm;
    } vec_t;

    vec_t vq[$];

    // {ir, pc, src, rd, rw, as, aop, mr, mw, m2r, ret, ill}
    function automatic logic [14:0] o(input logic ir, input logic pc, input logic [1:0] src,
                                      input logic rd, input logic rw, input logic as_,
                                      input logic [2:0] aop, input logic mr, input logic mw,
                                      input logic m2r, input logic ret, input logic ill);
        return {ir, pc, src, rd, rw, as_, aop, mr, mw, m2r, ret, ill};
    endfunction

    function automatic logic [14:0] outs();
        return {ir_write, pc_write, pc_src, reg_dst, reg_write, alu_src, alu_op,
                mem_read, mem_write, mem2reg, retire, illegal};
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [14:0] e, input string nm);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e; v.nm = nm;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Runs one instruction from FETCH with an n-cycle wait on every memory access;
    // returns cycles until retire (0 on timeout).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int n, output int cycles);
        int wl;
        cycles = 0;
        wl = n;
        opcode = op; funct = fn; zero = z;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            cycles++;
            if ((mem_read || mem_write) && wl > 0) begin
                mem_ready = 1'b0;
                wl--;
            end else begin
                mem_ready = 1'b1;
                if (mem_read || mem_write) wl = n;
            end
            @(negedge clk);
            if (retire) return;
        end
        cycles = 0;
    endtask

    logic [14:0] f_ok, f_wait, idle, zr, halt_o, wb_r;
    int cyc;

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

        f_ok   = o(1,1,0,0,0,0,2,1,0,0,0,0);
        f_wait = o(0,0,0,0,0,0,2,1,0,0,0,0);
        idle   = o(0,0,0,0,0,0,2,0,0,0,0,0);
        zr     = o(0,0,0,0,0,0,0,0,0,0,0,0);
        halt_o = o(0,0,0,0,0,0,2,0,0,0,0,1);
        wb_r   = o(0,0,0,1,1,0,2,0,0,0,1,0);

        add(0, 6'h00, 6'h20, 0, 1, zr,   "reset");
        add(1, 6'h00, 6'h20, 0, 1, f_ok, "add_f");
        add(1, 6'h00, 6'h20, 0, 1, idle, "add_d");
        add(1, 6'h00, 6'h20, 0, 1, idle, "add_e");
        add(1, 6'h00, 6'h20, 0, 1, wb_r, "add_w");
        add(1, 6'h00, 6'h22, 0, 1, f_ok, "sub_f");
        add(1, 6'h00, 6'h22, 0, 1, idle, "sub_d");
        add(1, 6'h00, 6'h22, 0, 1, o(0,0,0,0,0,0,6,0,0,0,0,0), "sub_e");
        add(1, 6'h00, 6'h22, 0, 1, wb_r, "sub_w");
        add(1, 6'h00, 6'h2A, 0, 1, f_ok, "slt_f");
        add(1, 6'h00, 6'h2A, 0, 1, idle, "slt_d");
        add(1, 6'h00, 6'h2A, 0, 1, o(0,0,0,0,0,0,7,0,0,0,0,0), "slt_e");
        add(1, 6'h00, 6'h2A, 0, 1, wb_r, "slt_w");
        add(1, 6'h08, 6'h00, 0, 1, f_ok, "addi_f");
        add(1, 6'h08, 6'h00, 0, 1, idle, "addi_d");
        add(1, 6'h08, 6'h00, 0, 1, o(0,0,0,0,0,1,2,0,0,0,0,0), "addi_e");
        add(1, 6'h08, 6'h00, 0, 1, o(0,0,0,0,1,0,2,0,0,0,1,0), "addi_w");
        add(1, 6'h23, 6'h00, 0, 1, f_ok, "lw_f");
        add(1, 6'h23, 6'h00, 0, 1, idle, "lw_d");
        add(1, 6'h23, 6'h00, 0, 1, o(0,0,0,0,0,1,2,0,0,0,0,0), "lw_e");
        add(1, 6'h23, 6'h00, 0, 0, o(0,0,0,0,0,1,2,1,0,0,0,0), "lw_m0");
        add(1, 6'h23, 6'h00, 0, 0, o(0,0,0,0,0,1,2,1,0,0,0,0), "lw_m1");
        add(1, 6'h23, 6'h00, 0, 1, o(0,0,0,0,0,1,2,1,0,0,0,0), "lw_m2");
        add(1, 6'h23, 6'h00, 0, 1, o(0,0,0,0,1,1,2,0,0,1,1,0), "lw_w");
        add(1, 6'h04, 6'h00, 1, 1, f_ok, "beq1_f");
        add(1, 6'h04, 6'h00, 1, 1, idle, "beq1_d");
        add(1, 6'h04, 6'h00, 1, 1, o(0,1,1,0,0,0,6,0,0,0,1,0), "beq1_e");
        add(1, 6'h04, 6'h00, 0, 1, f_ok, "beq0_f");
        add(1, 6'h04, 6'h00, 0, 1, idle, "beq0_d");
        add(1, 6'h04, 6'h00, 0, 1, o(0,0,0,0,0,0,6,0,0,0,1,0), "beq0_e");
        add(1, 6'h02, 6'h00, 0, 1, f_ok, "j_f");
        add(1, 6'h02, 6'h00, 0, 1, idle, "j_d");
        add(1, 6'h02, 6'h00, 0, 1, o(0,1,2,0,0,0,2,0,0,0,1,0), "j_e");
        add(1, 6'h2B, 6'h00, 0, 1, f_ok, "sw_f");
        add(1, 6'h2B, 6'h00, 0, 1, idle, "sw_d");
        add(1, 6'h2B, 6'h00, 0, 1, o(0,0,0,0,0,1,2,0,0,0,0,0), "sw_e");
        add(1, 6'h2B, 6'h00, 0, 1, o(0,0,0,0,0,1,2,0,1,0,1,0), "sw_m");
        add(1, 6'h00, 6'h25, 0, 0, f_wait, "or_fwait");
        add(1, 6'h00, 6'h25, 0, 1, f_ok, "or_f");
        add(1, 6'h00, 6'h25, 0, 1, idle, "or_d");
        add(1, 6'h00, 6'h25, 0, 1, o(0,0,0,0,0,0,1,0,0,0,0,0), "or_e");
        add(1, 6'h00, 6'h25, 0, 1, wb_r, "or_w");
        add(1, 6'h00, 6'h24, 0, 1, f_ok, "and_f");
        add(1, 6'h00, 6'h24, 0, 1, idle, "and_d");
        add(1, 6'h00, 6'h24, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0,0), "and_e");
        add(1, 6'h00, 6'h24, 0, 1, wb_r, "and_w");
        add(1, 6'h2B, 6'h00, 0, 1, f_ok, "swr_f");
        add(1, 6'h2B, 6'h00, 0, 1, idle, "swr_d");
        add(1, 6'h2B, 6'h00, 0, 1, o(0,0,0,0,0,1,2,0,0,0,0,0), "swr_e");
        add(1, 6'h2B, 6'h00, 0, 0, o(0,0,0,0,0,1,2,0,1,0,0,0), "swr_mwait");
        add(0, 6'h2B, 6'h00, 0, 0, zr,   "swr_rst");
        add(1, 6'h3F, 6'h00, 0, 1, f_ok, "ill_f");
        add(1, 6'h3F, 6'h00, 0, 1, idle, "ill_d");
        add(1, 6'h3F, 6'h00, 0, 1, halt_o, "ill_h0");
        add(1, 6'h00, 6'h20, 1, 0, halt_o, "ill_h1");
        add(1, 6'h00, 6'h20, 0, 1, halt_o, "ill_h2");
        add(0, 6'h00, 6'h20, 0, 1, zr,   "ill_rst");
        add(1, 6'h00, 6'h21, 0, 1, f_ok, "illfn_f");
        add(1, 6'h00, 6'h21, 0, 1, idle, "illfn_d");
        add(1, 6'h00, 6'h21, 0, 1, halt_o, "illfn_h");
        add(0, 6'h00, 6'h21, 0, 1, zr,   "illfn_rst");
        add(1, 6'h02, 6'h00, 0, 1, f_ok, "post_f");
        add(1, 6'h02, 6'h00, 0, 1, idle, "post_d");
        add(1, 6'h02, 6'h00, 0, 1, o(0,1,2,0,0,0,2,0,0,0,1,0), "post_e");

        foreach (vq[i]) begin
            @(posedge clk); #1;
            rst_n = vq[i].rst; opcode = vq[i].op; funct = vq[i].fn;
            zero = vq[i].z; mem_ready = vq[i].rdy;
            @(negedge clk);
            check(vq[i].nm, {17'd0, outs()}, {17'd0, vq[i].exp});
        end

        // Now in FETCH: multi-cycle sequences with stalled memory accesses.
        run_instr(6'h23, 6'h00, 0, 3, cyc);
        check("lw_stall3_cycles", cyc, 11);
        run_instr(6'h2B, 6'h00, 0, 2, cyc);
        check("sw_stall2_cycles", cyc, 8);
        run_instr(6'h00, 6'h2A, 0, 4, cyc);
        check("slt_stall4_cycles", cyc, 8);
        run_instr(6'h04, 6'h00, 1, 1, cyc);
        check("beq_stall1_cycles", cyc, 4);

`ifdef MC_CTRL_PERF_EN
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(6'h00, 6'h20, 0, 0, cyc);
        check("perf_r_cycles", cyc, 4);
        run_instr(6'h02, 6'h00, 0, 0, cyc);
        check("perf_j_cycles", cyc, 3);
        @(posedge clk); #1;
        check("perf_cyc_cnt", cyc_cnt, 7);
        check("perf_ret_cnt", ret_cnt, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
